demux_3w_1_to_5: RTL

//  Registered 1-to-5 demultiplexer: the distribution counterpart of the 3-wide 5-to-1 mux.
//  - Steers a WIDTH-bit input word to one of five output channels (u,v,w,x,y), chosen by sel.
//  - Each channel has a one-entry holding register with a valid/ready handshake.
//  - Sits between a single producer and five independent consumers.
//  - Out-of-range selects are dropped and counted.

---
 rtl/demux_3w_1_to_5.sv | 115 +++++++++++
 1 files changed

// File: rtl/demux_3w_1_to_5.sv
// Registered 1-to-5 demultiplexer with per-channel one-entry holding
// registers, valid/ready handshakes and a saturating drop counter.
module demux_3w_1_to_5 #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_u,
  output logic [WIDTH-1:0] out_v,
  output logic [WIDTH-1:0] out_w,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [4:0]       out_valid,
  input  logic [4:0]       out_ready,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] drop_count
);

  localparam int NCH = 5;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t        state_q [NCH];
  ch_state_t        state_d [NCH];
  logic [WIDTH-1:0] data_q  [NCH];

  logic           sel_ok;
  logic           take;
  logic [NCH-1:0] wr;
  logic           drop;

  assign sel_ok = (sel < 3'd5);

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      out_valid[i] = (state_q[i] == FULL);
    end
  end

  // Ready only looks at the addressed channel; bad selects always drain.
  always_comb begin
    in_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (sel == 3'(i)) begin
        in_ready = !out_valid[i] || out_ready[i];
      end
    end
  end

  assign take = in_valid && in_ready && !reset;
  assign drop = take && !sel_ok;

  always_comb begin
    wr = '0;
    for (int i = 0; i < NCH; i++) begin
      wr[i] = take && (sel == 3'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        EMPTY: begin
          if (wr[i]) state_d[i] = FULL;
        end
        FULL: begin
          if (out_ready[i] && !wr[i]) state_d[i] = EMPTY;
        end
        default: state_d[i] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        if (wr[i]) data_q[i] <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  assign out_u = data_q[0];
  assign out_v = data_q[1];
  assign out_w = data_q[2];
  assign out_x = data_q[3];
  assign out_y = data_q[4];

endmodule
